// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//
// Synthesizable boot path for the pipelined core. It takes a length-prefixed
// byte stream and writes the image into instruction memory through the
// memory's write port. When the image is complete it releases the core
// through resetpc.
//
// Stream format:
//   byte 0 : len[7:0]
//   byte 1 : len[15:8]
//   then 4*len bytes, one 32-bit word per four bytes, least significant first.
//   Words go to byte addresses 0, 4, 8, ...
//
// Ports:
//   clk       in   system clock, all state on rising edge
//   reset     in   asynchronous active-low reset
//   rx_valid  in   rx_data holds a valid byte
//   rx_data   in   incoming byte
//   rx_ready  out  loader accepts a byte this cycle (transfer = rx_valid & rx_ready)
//   reload    in   synchronous pulse: drop current image, hold core, restart
//   we0       out  instruction-memory write enable, one-cycle pulse per word
//   wr_addr0  out  byte address of the write (always word aligned)
//   wr_din0   out  instruction word to write
//   resetpc   out  0 = core held at PC reset, 1 = core runs
//   done      out  image fully written, core released
//   error     out  header length exceeded DEPTH_WORDS
//
// State table:
//   S_LEN_LO | waiting for the low length byte
//   S_LEN_HI | waiting for the high length byte, then decide DATA/RUN/ERR
//   S_DATA   | collecting the four bytes of the current word
//   S_WRITE  | one-cycle write of the assembled word
//   S_RUN    | image complete, core released, stream ignored
//   S_ERR    | header too long, core held, no writes, stream ignored
// -----------------------------------------------------------------------------
module imem_boot_loader #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH_WORDS = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic              reload,
    output logic              we0,
    output logic [ADDR_W-1:0] wr_addr0,
    output logic [31:0]       wr_din0,
    output logic              resetpc,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_WRITE  = 3'd3,
        S_RUN    = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // Only the first three bytes of a word are buffered; the fourth byte goes
    // straight into the write-data register together with them.
    logic [23:0]       lane_q, lane_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       din_q, din_d;

    logic              receiving;
    logic              xfer;
    logic              we_c;
    logic [15:0]       hdr_len;

    assign receiving = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);

    // rx_ready is forced low while reset is held (the state register already
    // sits at S_LEN_LO then) and during a reload cycle, so a byte offered
    // together with reload is never consumed.
    assign rx_ready = receiving & reset & ~reload;
    assign xfer     = rx_valid & rx_ready;

    // -------------------------------------------------------------------------
    // Next-state / datapath logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        lane_d     = lane_q;
        addr_d     = addr_q;
        din_d      = din_q;
        we_c       = 1'b0;
        hdr_len    = {rx_data, len_q[7:0]};

        if (reload) begin
            // Pending word (if in S_WRITE) is dropped: we_c stays low.
            state_d    = S_LEN_LO;
            len_d      = 16'd0;
            word_idx_d = 16'd0;
            byte_cnt_d = 2'd0;
            lane_d     = 24'd0;
        end else begin
            case (state_q)
                S_LEN_LO: begin
                    if (xfer) begin
                        len_d[7:0] = rx_data;
                        state_d    = S_LEN_HI;
                    end
                end

                S_LEN_HI: begin
                    if (xfer) begin
                        len_d[15:8] = rx_data;
                        if (hdr_len == 16'd0) begin
                            state_d = S_RUN;
                        end else if (hdr_len > 16'(DEPTH_WORDS)) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        case (byte_cnt_q)
                            2'd0: lane_d[7:0]   = rx_data;
                            2'd1: lane_d[15:8]  = rx_data;
                            2'd2: lane_d[23:16] = rx_data;
                            default: begin
                                din_d   = {rx_data, lane_q};
                                addr_d  = {word_idx_q[ADDR_W-3:0], 2'b00};
                                state_d = S_WRITE;
                            end
                        endcase
                        // Wraps 3 -> 0 on the last byte of the word.
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end

                S_WRITE: begin
                    we_c       = 1'b1;
                    word_idx_d = word_idx_q + 16'd1;
                    if ((word_idx_q + 16'd1) == len_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DATA;
                    end
                end

                S_RUN: begin
                    state_d = S_RUN;
                end

                S_ERR: begin
                    state_d = S_ERR;
                end

                default: begin
                    state_d = S_LEN_LO;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_LEN_LO;
            len_q      <= 16'd0;
            word_idx_q <= 16'd0;
            byte_cnt_q <= 2'd0;
            lane_q     <= 24'd0;
            addr_q     <= '0;
            din_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            byte_cnt_q <= byte_cnt_d;
            lane_q     <= lane_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign we0      = we_c;
    assign wr_addr0 = addr_q;
    assign wr_din0  = din_q;
    assign resetpc  = (state_q == S_RUN);
    assign done     = (state_q == S_RUN);
    assign error    = (state_q == S_ERR);

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Byte-stream program loader sitting directly upstream of the pipelined core's instruction-memory write port (we0/wr_addr0/wr_din0) and its resetpc input. It receives a length-prefixed byte stream, assembles little-endian 32-bit instruction words, and writes them to consecutive word addresses. When the image is complete it releases the core by asserting resetpc. This replaces bench-driven memory preloading with a synthesizable boot path.

Parameters:
ADDR_W, 9, byte-address width of instruction memory write port
DEPTH_WORDS, 128, maximum number of loadable words (must be <= 2**(ADDR_W-2))

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
rx_valid  input  1  rx_data holds a valid byte
rx_data  input  8  incoming byte
rx_ready  output  1  loader accepts a byte this cycle (transfer = rx_valid & rx_ready)
reload  input  1  synchronous pulse: abort/finish current image, hold core, restart load
we0  output  1  instruction-memory write enable, one-cycle pulse per word
wr_addr0  output  ADDR_W  byte address of write, always multiple of 4
wr_din0  output  32  instruction word to write
resetpc  output  1  0 = core held at PC reset, 1 = core runs
done  output  1  image fully written, core released
error  output  1  header length exceeded DEPTH_WORDS

Behaviour:
- Reset (reset=0, asynchronous): state=LEN_LO; we0=0, wr_addr0=0, wr_din0=0, resetpc=0, done=0, error=0, rx_ready=0 during reset; word counter, byte counter, length register cleared.
- Stream format: byte0=len[7:0], byte1=len[15:8], then 4*len bytes, each word LSB first.
- States:
  - LEN_LO: rx_ready=1; on transfer latch len[7:0] -> LEN_HI.
  - LEN_HI: rx_ready=1; on transfer latch len[15:8]; next state: len==0 -> RUN; len>DEPTH_WORDS -> ERR; else -> DATA.
  - DATA: rx_ready=1; on transfer place byte into lane byte_cnt (0..3) of word buffer, byte_cnt++; on 4th byte -> WRITE.
  - WRITE: rx_ready=0; exactly one cycle with we0=1, wr_addr0=4*word_idx, wr_din0=assembled word; word_idx++; if word_idx+1==len -> RUN else -> DATA.
  - RUN: rx_ready=0, resetpc=1, done=1; incoming bytes not accepted.
  - ERR: rx_ready=0, error=1, resetpc=0; no writes.
- Latency: we0 asserted the cycle after the 4th byte transfer of a word; resetpc rises the cycle after the last we0 pulse.
- we0 is 0 in every state except WRITE; wr_addr0/wr_din0 hold last values otherwise.
- rx_valid gaps: loader waits indefinitely in any receiving state; partial words are held.
- Address never wraps: len<=DEPTH_WORDS guarantees wr_addr0 <= 4*(DEPTH_WORDS-1).
- reload=1 (any state, priority over transfer in same cycle): next cycle state=LEN_LO, resetpc=0, done=0, error=0, counters cleared; no we0 that cycle even if in WRITE (the pending word is dropped).
- Asynchronous reset mid-load: all outputs return to reset values immediately; memory contents already written are left as-is.

Test Plan:
- Reset then stream 02 00 | 13 00 50 00 | 93 00 10 00 -> we0 pulses with (addr 0, 0x00500013) and (addr 4, 0x00100093); resetpc=1, done=1 the cycle after second pulse.
- Header 00 00 -> no we0 pulse; resetpc=1 one cycle after second header byte.
- Header 81 00 (129 > 128) -> error=1, resetpc=0, rx_ready=0, no we0 ever; reload then valid 1-word image -> error clears, image loads at addr 0.
- Full 128-word image with rx_valid toggling every other cycle -> 128 pulses, last at wr_addr0=508 (9'h1FC), addresses strictly +4, done after last.
- After RUN, assert reload, stream 01 00 | EF BE AD DE -> resetpc drops next cycle, single write addr 0 data 0xDEADBEEF, resetpc reasserts.
- Drop reset to 0 after 2 bytes of a word, release, send 01 00 | 78 56 34 12 -> outputs zero during reset; single write addr 0 data 0x12345678 (no stale bytes).
